// File: rtl/minrv32_mem_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the minrv32 memory bridge: FSM states, default SRAM window,
// and the request legality check reused by the core-side assertions.
package minrv32_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SRAM,
        ST_WAIT,
        ST_RESP,
        ST_ERR
    } bridge_state_e;

    localparam logic [31:0] DEFAULT_BASE_ADDR   = 32'h0001_0000;
    localparam int unsigned DEFAULT_DEPTH_WORDS = 16384;

    // In-window, word-aligned, and not an instruction fetch that tries to write.
    function automatic logic req_legal(
        input logic [31:0] addr,
        input logic        instr,
        input logic [3:0]  wstrb,
        input logic [31:0] base,
        input int unsigned depth_words
    );
        logic [32:0] limit;
        logic        in_window;
        limit     = {1'b0, base} + (33'(depth_words) << 2);
        in_window = ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < limit);
        return in_window && (addr[1:0] == 2'b00) && !(instr && (wstrb != 4'b0000));
    endfunction

endpackage

// File: rtl/minrv32_sram_sp.sv
`timescale 1ns/1ps
// Behavioural single-port synchronous SRAM for simulation benches:
// 1-cycle read latency, per-byte write enables, read data only updated on reads.
module minrv32_sram_sp #(
    parameter  int unsigned DEPTH_WORDS = 16384,
    localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          ce,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // NOTE: the array has no reset; clearing a RAM needs a sweep FSM, and real macros cannot do it.
    always_ff @(posedge clk) begin
        if (ce) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
            if (we == 4'b0000) begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/minrv32_mem_bridge.sv
`timescale 1ns/1ps
// Memory-side slave for the minrv32 native bus: issues one SRAM access per legal request,
// inserts WAIT_STATES extra cycles, and answers illegal requests with a bus error pulse.
module minrv32_mem_bridge
    import minrv32_mem_pkg::*;
#(
    parameter  logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter  int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter  int unsigned WAIT_STATES = 0,
    localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          mem_valid,
    input  logic          mem_instr,
    input  logic [31:0]   mem_addr,
    input  logic [31:0]   mem_wdata,
    input  logic [3:0]    mem_wstrb,
    output logic          mem_ready,
    output logic [31:0]   mem_rdata,
    output logic          bus_err,
    output logic          sram_ce,
    output logic [3:0]    sram_we,
    output logic [AW-1:0] sram_addr,
    output logic [31:0]   sram_wdata,
    input  logic [31:0]   sram_rdata
);

    bridge_state_e state_q, state_d;
    logic [3:0]    wait_cnt_q;
    logic [31:0]   rdata_q;
    logic          write_q;
    logic          legal;

    assign legal      = req_legal(mem_addr, mem_instr, mem_wstrb, BASE_ADDR, DEPTH_WORDS);
    assign sram_addr  = AW'((mem_addr - BASE_ADDR) >> 2);
    assign sram_wdata = mem_wdata;

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        sram_ce   = 1'b0;
        sram_we   = 4'b0000;
        mem_ready = 1'b0;
        bus_err   = 1'b0;
        mem_rdata = 32'h0;
        unique case (state_q)
            ST_IDLE: begin
                if (mem_valid) begin
                    if (legal) begin
                        // The strobe is combinational, so gate it off while reset is held.
                        sram_ce = resetn;
                        sram_we = resetn ? mem_wstrb : 4'b0000;
                        state_d = ST_SRAM;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_SRAM: state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
            ST_WAIT: begin
                if (wait_cnt_q == 4'd1) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                mem_ready = 1'b1;
                mem_rdata = rdata_q;
                state_d   = ST_IDLE;
            end
            ST_ERR: begin
                mem_ready = 1'b1;
                bus_err   = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 4'd0;
            rdata_q    <= 32'h0;
            write_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && mem_valid) begin
                write_q <= (mem_wstrb != 4'b0000);
            end
            if (state_q == ST_SRAM) begin
                rdata_q    <= write_q ? 32'h0 : sram_rdata;
                wait_cnt_q <= 4'(WAIT_STATES);
            end else if (state_q == ST_WAIT) begin
                wait_cnt_q <= wait_cnt_q - 4'd1;
            end
        end
    end

endmodule

// File: doc/minrv32_mem_bridge.md
# minrv32_mem_bridge

Memory-side slave for the minrv32 native memory bus. It turns the core's valid/ready requests (instruction fetch, load, store) into accesses on a single-port synchronous SRAM, with a configurable number of wait states. Out-of-window, misaligned and illegal requests complete with an error pulse and never touch the SRAM. It sits directly downstream of the core's mem_* port, in both the SoC top and the formal/simulation benches.

## Interface
- BASE_ADDR, 32'h0001_0000, byte address of SRAM word 0; must be DEPTH_WORDS*4 aligned.
- DEPTH_WORDS, 16384, SRAM depth in 32-bit words; power of two.
- WAIT_STATES, 0, extra cycles inserted before each SRAM response; range 0..15.
- AW (localparam), $clog2(DEPTH_WORDS), SRAM address width.
- Clocking and reset (already decided): one clock; reset is asynchronous and active-low. Ports clk and resetn.
- clk  in  1  rising-edge clock.
- resetn  in  1  asynchronous reset, active-low.
- mem_valid  in  1  request pending; address and data held stable until mem_ready.
- mem_instr  in  1  request is an instruction fetch.
- mem_addr  in  32  byte address.
- mem_wdata  in  32  store data.
- mem_wstrb  in  4  byte write enables; 0 means read.
- mem_ready  out  1  one-cycle completion pulse.
- mem_rdata  out  32  read data, valid only while mem_ready=1.
- bus_err  out  1  asserted together with mem_ready on an error completion.
- sram_ce  out  1  SRAM access strobe.
- sram_we  out  4  SRAM byte write enables.
- sram_addr  out  AW  SRAM word address.
- sram_wdata  out  32  SRAM write data.
- sram_rdata  in  32  SRAM read data, valid the cycle after sram_ce.

## Operation
- Window check: a request is legal only if all three hold:
  - BASE_ADDR <= mem_addr < BASE_ADDR + 4*DEPTH_WORDS;
  - mem_addr[1:0] == 0;
  - not (mem_instr && mem_wstrb != 0).
- FSM states: IDLE, SRAM, WAIT, RESP, ERR.
- IDLE, mem_valid=1 and legal:
  - sram_ce=1, combinationally in this cycle;
  - sram_we=mem_wstrb, sram_addr=(mem_addr-BASE_ADDR)>>2, sram_wdata=mem_wdata;
  - next state SRAM.
- IDLE, mem_valid=1 and illegal: no SRAM access; next state ERR.
- SRAM:
  - on a read, capture sram_rdata into rdata_q; on a write, clear rdata_q to 0;
  - next state WAIT if WAIT_STATES>0 (load wait counter), otherwise RESP.
- WAIT: decrement the counter; go to RESP when it expires after exactly WAIT_STATES cycles.
- RESP: mem_ready=1, mem_rdata=rdata_q, bus_err=0; next state IDLE.
- ERR: mem_ready=1, bus_err=1, mem_rdata=0; next state IDLE.
- Outside IDLE, sram_ce=0 and sram_we=0.
- Outside RESP and ERR, mem_ready=0 and bus_err=0. mem_rdata is 0 whenever mem_ready=0.
- mem_valid dropping mid-transaction is a protocol violation. The bridge finishes the transaction regardless; the SRAM effect already happened in IDLE.
- Back-to-back: a request held on mem_valid after mem_ready is a new request, sampled the cycle after RESP/ERR, in IDLE.

## Timing
- Legal request: mem_valid first seen in IDLE at cycle N. mem_ready is high for exactly cycle N+2+WAIT_STATES.
- Error request: mem_ready and bus_err are high for exactly cycle N+1.
- Request throughput: one per 3+WAIT_STATES cycles (legal), one per 2 cycles (error).
- Reset (resetn low, asynchronous):
  - state=IDLE; wait counter, rdata_q, mem_ready, bus_err and mem_rdata all 0;
  - sram_ce and sram_we are 0 while in reset;
  - abandoned transactions never produce mem_ready;
  - a write strobed before reset asserted may already have committed.
- First request is sampled on the first rising edge after resetn deasserts.

## Structure
- Shared package minrv32_mem_pkg holds:
  - the state enum (IDLE, SRAM, WAIT, RESP, ERR);
  - the default BASE_ADDR/DEPTH_WORDS constants;
  - a window/legality check function, reused by the core-side assertions.
- Wait counter and decode stay inline in the bridge.
- Test-only sub-module minrv32_sram_sp: behavioural single-port synchronous SRAM, 1-cycle read latency, byte writes.

## Test plan
- Reset: hold resetn=0 with mem_valid=1 -> mem_ready, bus_err, mem_rdata, sram_ce and sram_we all 0. After release, the first request is accepted.
- Word write then read, WAIT_STATES=0:
  - store 0xDEADBEEF to 0x0001_0004, wstrb=0xF -> sram_ce=1, sram_addr=1 at cycle 0; mem_ready at cycle 2;
  - load 0x0001_0004 -> mem_rdata=0xDEADBEEF with mem_ready at cycle 2.
- Byte write: wstrb=0x2, wdata=0x0000AB00 to 0x0001_0004, then load -> mem_rdata=0xDEADABEF.
- WAIT_STATES=3: load -> mem_ready exactly one cycle wide at cycle 5; sram_ce exactly one cycle wide at cycle 0.
- Errors, each giving mem_ready=bus_err=1 at cycle 1, mem_rdata=0, and sram_ce never asserted:
  - load from 0x0002_0000 (out of window);
  - load from 0x0001_0002 (misaligned);
  - mem_instr=1 with wstrb=0xF (illegal fetch-write).
- Back-to-back and reset abort:
  - mem_valid held across loads of 0x0001_0000 then 0x0001_0008 -> ready pulses at cycles 2 and 5;
  - resetn pulsed low in cycle 1 of a load -> no mem_ready for that load; FSM in IDLE after release.
